// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encoding and default bit timing shared by the UART blocks.
package uart_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
   localparam int DEF_CLKS_PER_BIT = 1087;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: multi-flop synchronizer for an asynchronous line that idles high.
module uart_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [SYNC_STAGES-1:0] ff;
   always_ff @(posedge clk)
      if (rst) ff <= '1;
      else     ff <= {ff[SYNC_STAGES-2:0], d};
   assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first receiver with valid/ready output, frame error and overrun pulses.
module uart_rx import uart_pkg::*; #(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_input,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
   uart_state_t   state;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shift;
   logic          hold_off;
   logic          rxs;
   logic          expire;
   uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(rx_input), .q(rxs));
   assign expire = cnt == CW'(1);
   // After reset or a bad stop bit the line must stay high for more than a bit
   // time before a falling edge can start a frame, so mid-frame lows are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shift     <= '0;
         hold_off  <= 1'b1;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         if (rx_valid && rx_ready) rx_valid <= 1'b0;
         case (state)
            IDLE:
               if (hold_off) begin
                  cnt <= rxs ? cnt + 1'b1 : '0;
                  if (rxs && cnt == FULL) begin
                     hold_off <= 1'b0;
                     cnt      <= '0;
                  end
               end else if (!rxs) begin
                  state <= START;
                  cnt   <= HALF;
                  busy  <= 1'b1;
               end
            START:
               if (!expire) cnt <= cnt - 1'b1;
               else if (rxs) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  state <= DATA;
                  cnt   <= FULL;
                  idx   <= '0;
               end
            DATA:
               if (!expire) cnt <= cnt - 1'b1;
               else begin
                  shift[idx] <= rxs;
                  cnt        <= FULL;
                  idx        <= idx + 1'b1;
                  if (idx == 3'd7) state <= STOP;
               end
            STOP:
               if (!expire) cnt <= cnt - 1'b1;
               else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
                  if (rxs) begin
                     rx_data  <= shift;
                     rx_valid <= 1'b1;
                     overrun  <= rx_valid && !rx_ready;
                  end else begin
                     frame_err <= 1'b1;
                     hold_off  <= 1'b1;
                  end
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed frames checked cycle by cycle against a frame-level model.
module tb_uart_rx;
   localparam int CPB  = 16;
   localparam int SYNC = 2;
   localparam int HALF = CPB / 2;
   localparam int LAT  = SYNC + 1 + HALF + 9 * CPB;
   logic clk = 1'b0, rst = 1'b1, rx_input = 1'b1, rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic rx_valid, frame_err, overrun, busy;
   uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst(rst), .rx_input(rx_input), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy));
   always #5 clk = ~clk;
   int cyc = 0, n_vec = 0, n_bad = 0;
   int ready_mode = 0, next_done = 0;
   logic [8:0] evt [int];
   int busy_lo[$], busy_hi[$];
   logic m_valid = 1'b0, m_fe = 1'b0, m_ov = 1'b0, m_busy = 1'b0;
   logic [7:0] m_data = 8'h00;
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %h want %h", tag, cyc, got, exp);
      end
   endtask
   // Frame-level model: each frame's outcome lands LAT edges after its start bit is driven.
   always @(posedge clk) begin : model
      int k;
      logic v, fe, ov, b;
      logic [7:0] d;
      k = cyc + 1;
      if (rst) begin
         evt.delete();
         busy_lo.delete();
         busy_hi.delete();
         m_valid <= 1'b0;
         m_data  <= 8'h00;
         m_fe    <= 1'b0;
         m_ov    <= 1'b0;
         m_busy  <= 1'b0;
      end else begin
         v = m_valid; d = m_data; fe = 1'b0; ov = 1'b0; b = 1'b0;
         if (evt.exists(k) && evt[k][8]) begin
            ov = v && !rx_ready;
            v  = 1'b1;
            d  = evt[k][7:0];
         end else begin
            fe = evt.exists(k);
            if (v && rx_ready) v = 1'b0;
         end
         foreach (busy_lo[i]) if (busy_lo[i] <= k && k < busy_hi[i]) b = 1'b1;
         m_valid <= v;
         m_data  <= d;
         m_fe    <= fe;
         m_ov    <= ov;
         m_busy  <= b;
      end
      cyc <= k;
   end
   always @(negedge clk) begin
      chk("rx_valid", {7'b0, rx_valid}, {7'b0, m_valid});
      chk("rx_data", rx_data, m_data);
      chk("frame_err", {7'b0, frame_err}, {7'b0, m_fe});
      chk("overrun", {7'b0, overrun}, {7'b0, m_ov});
      chk("busy", {7'b0, busy}, {7'b0, m_busy});
   end
   initial forever begin
      @(posedge clk); #1;
      rx_ready = ready_mode == 1 || (ready_mode == 2 && $urandom_range(0, 39) == 0) ||
                 (ready_mode == 3 && cyc + 1 == next_done);
   end
   task automatic tick();
      @(posedge clk); #1;
   endtask
   task automatic idle(input int n);
      rx_input = 1'b1;
      repeat (n) tick();
   endtask
   task automatic send(input logic [7:0] b, input logic stop, input int rst_at);
      logic [9:0] f;
      int s;
      f = {stop, b, 1'b0};
      s = cyc;
      evt[s + LAT] = {stop, b};
      busy_lo.push_back(s + SYNC + 1);
      busy_hi.push_back(s + LAT);
      next_done = s + LAT;
      for (int i = 0; i < 10; i++)
         for (int c = 0; c < CPB; c++) begin
            rx_input = f[i];
            if (rst_at >= 0 && i * CPB + c == rst_at) rst = 1'b1;
            if (rst_at >= 0 && i * CPB + c == rst_at + 3) rst = 1'b0;
            tick();
         end
   endtask
   task automatic glitch(input int len);
      busy_lo.push_back(cyc + SYNC + 1);
      busy_hi.push_back(cyc + SYNC + 1 + HALF);
      rx_input = 1'b0;
      repeat (len) tick();
      rx_input = 1'b1;
   endtask
   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      idle(24);
      ready_mode = 0;
      send(8'h41, 1'b1, -1); idle(20);
      ready_mode = 1; idle(4);
      send(8'h41, 1'b1, -1); send(8'h42, 1'b1, -1); send(8'h43, 1'b1, -1); idle(20);
      glitch(5); idle(20);
      send(8'h46, 1'b0, -1); idle(2 * CPB);
      send(8'h44, 1'b1, -1); idle(20);
      ready_mode = 0;
      send(8'h45, 1'b1, -1); send(8'h46, 1'b1, -1); idle(20);
      ready_mode = 3;
      send(8'h47, 1'b1, -1); idle(20);
      ready_mode = 1; idle(4);
      ready_mode = 0;
      send(8'h41, 1'b1, 4 * CPB + 6); idle(2 * CPB);
      send(8'h42, 1'b1, -1); idle(20);
      ready_mode = 1; idle(4);
      ready_mode = 2;
      for (int n = 0; n < 40; n++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r == 0) begin
            glitch($urandom_range(1, 7));
            idle(16 + $urandom_range(0, 10));
         end else if (r == 1) begin
            send(8'($urandom), 1'b0, -1);
            idle(2 * CPB + $urandom_range(0, 10));
         end else begin
            send(8'($urandom), 1'b1, -1);
            idle($urandom_range(0, 2) == 0 ? 0 : $urandom_range(1, 30));
         end
      end
      idle(200);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
